// File: rtl/slc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// slc3_mem_pkg
//   Shared types and constants for the SLC-3 memory responder.
//   - mem_state_e : preload FSM states
//   - IO_ADDR     : word address of the memory-mapped switch/hex register
//   - rd_req_t    : decoded read request carried into the read pipe
//   - decode_rd() : classifies a request address for the read path
// -----------------------------------------------------------------------------
package slc3_mem_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } mem_state_e;

   localparam logic [15:0] IO_ADDR = 16'hFFFF;

   typedef struct packed {
      logic valid;   // a read was accepted this cycle
      logic is_io;   // targets the switch register
      logic is_oor;  // neither RAM nor I/O: returns zero
   } rd_req_t;

   // in_ram is computed by the caller because the RAM size is a module parameter.
   function automatic rd_req_t decode_rd(input logic        fire,
                                         input logic [15:0] addr,
                                         input logic        in_ram);
      rd_req_t r;
      r.valid  = fire;
      r.is_io  = (addr == IO_ADDR);
      r.is_oor = !in_ram && (addr != IO_ADDR);
      return r;
   endfunction

endpackage

// File: rtl/slc3_mem_responder_init_rom.sv
// -----------------------------------------------------------------------------
// init_rom
//   DEPTH x 16 synchronous ROM holding the SLC-3 program image that is copied
//   into RAM after reset. One-cycle read: data_o reflects addr_i of the
//   previous rising edge.
//   Image: words 0..7 are a short boot program, every later word k holds
//   k XOR 16'hA5A5 as a recognisable fill pattern.
// Ports
//   clk     in   1              rising-edge clock
//   addr_i  in   log2(DEPTH)    word address
//   data_o  out  16             registered ROM word
// -----------------------------------------------------------------------------
module init_rom #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   output logic [15:0]              data_o
);

   localparam int AW = $clog2(DEPTH);

   function automatic logic [15:0] image_word(input logic [AW-1:0] a);
      logic [15:0] a16;
      logic [15:0] w;
      a16 = 16'(a);
      case (a16)
         16'd0:   w = 16'h5020;  // AND R0,R0,#0
         16'd1:   w = 16'h1021;  // ADD R0,R0,#1
         16'd2:   w = 16'h3200;
         16'd3:   w = 16'h0FFE;
         16'd4:   w = 16'hE002;
         16'd5:   w = 16'hC1C0;
         16'd6:   w = 16'h7000;
         16'd7:   w = 16'hF025;  // HALT
         default: w = a16 ^ 16'hA5A5;
      endcase
      return w;
   endfunction

   // NOTE: clocked state is always assigned with <= so every flop samples the
   // pre-edge values; = here would create order-dependent simulation results.
   always_ff @(posedge clk) begin
      data_o <= image_word(addr_i);
   end

endmodule

// File: rtl/slc3_mem_responder.sv
// -----------------------------------------------------------------------------
// slc3_mem_responder
//   Memory-side responder for the SLC-3 mem_* initiator bus. Owns the program/
//   data RAM and the I/O register. After reset it copies init_rom into RAM
//   (INIT), then serves CPU reads/writes (READY) until the next reset.
//   Address map: 0..RAM_DEPTH-1 RAM, 16'hFFFF switches (read) / hex (write),
//   anything else reads as zero and ignores writes.
//   Writes take effect at the request edge. Reads are captured at the request
//   edge and mem_rdata is updated READ_LAT-1 edges later (valid READ_LAT
//   cycles after the request); back-to-back reads stream one per cycle.
// Parameters
//   RAM_DEPTH  RAM words, power of two, 16..32768
//   READ_LAT   request edge to valid data, 1..3
// Build option
//   SW_SYNC_EN  when defined, sw_i passes a 2-flop synchronizer before the
//               I/O read mux; otherwise it is sampled at the request edge.
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   mem_mem_ena  in   1   request strobe
//   mem_wr_ena   in   1   1 = write, 0 = read (qualified by mem_mem_ena)
//   mem_addr     in   16  word address
//   mem_wdata    in   16  write data
//   mem_rdata    out  16  registered read data, holds until the next read
//   sw_i         in   16  board switches
//   hex_o        out  16  hex display register
//   init_done_o  out  1   high once the preload has finished
// -----------------------------------------------------------------------------
module slc3_mem_responder
   import slc3_mem_pkg::*;
#(
   parameter int RAM_DEPTH = 1024,
   parameter int READ_LAT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_mem_ena,
   input  logic        mem_wr_ena,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   input  logic [15:0] sw_i,
   output logic [15:0] hex_o,
   output logic        init_done_o
);

   localparam int           AW     = $clog2(RAM_DEPTH);
   localparam logic [AW:0]  K_ONE  = (AW+1)'(1);
   localparam logic [AW:0]  K_LAST = (AW+1)'(RAM_DEPTH);
   localparam logic [AW-1:0] A_ONE = AW'(1);

   // ---------------------------------------------------------------------------
   // Preload FSM: k_q issues ROM read k, and the word returned one edge later
   // is written to RAM[k-1]. k_q runs one past the last ROM address so the
   // final write lands on the same edge that enters READY.
   // ---------------------------------------------------------------------------
   mem_state_e    state_q, state_d;
   logic [AW:0]   k_q, k_d;
   logic          init_we;
   logic [AW-1:0] init_waddr;
   logic [15:0]   rom_data;

   init_rom #(
      .DEPTH (RAM_DEPTH)
   ) u_init_rom (
      .clk    (clk),
      .addr_i (k_q[AW-1:0]),
      .data_o (rom_data)
   );

   // Wraps to RAM_DEPTH-1 when k_q == RAM_DEPTH, the last write target.
   assign init_waddr = k_q[AW-1:0] - A_ONE;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      k_d     = k_q;
      init_we = 1'b0;
      case (state_q)
         INIT: begin
            init_we = (k_q != '0);
            if (k_q == K_LAST) begin
               state_d = READY;
            end else begin
               k_d = k_q + K_ONE;
            end
         end
         default: ;  // READY is terminal until reset
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   assign init_done_o = (state_q == READY);

   // ---------------------------------------------------------------------------
   // CPU request decode. Nothing from the CPU is accepted until READY.
   // ---------------------------------------------------------------------------
   logic    cpu_ok;
   logic    in_ram;
   logic    hex_we;
   rd_req_t req_s0;

   assign cpu_ok = (state_q == READY) && mem_mem_ena;
   assign in_ram = (mem_addr[15:AW] == '0);
   assign hex_we = cpu_ok && mem_wr_ena && (mem_addr == IO_ADDR);
   assign req_s0 = decode_rd(cpu_ok && !mem_wr_ena, mem_addr, in_ram);

   // ---------------------------------------------------------------------------
   // Single-port RAM: the preload owns the port in INIT, the CPU in READY.
   // Reads and writes never share an edge because only one request arrives per
   // cycle, so a read in the cycle after a write sees the new word.
   // ---------------------------------------------------------------------------
   logic [15:0]   ram_q [RAM_DEPTH];
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata;

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = mem_addr[AW-1:0];
      ram_wdata = mem_wdata;
      if (state_q == INIT) begin
         ram_we    = init_we;
         ram_addr  = init_waddr;
         ram_wdata = rom_data;
      end else begin
         ram_we    = cpu_ok && mem_wr_ena && in_ram;
      end
   end

   // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
   // inference, and its contents are defined by the preload anyway.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_addr] <= ram_wdata;
      end
   end

   assign ram_rdata = ram_q[ram_addr];

   // ---------------------------------------------------------------------------
   // Switch source for I/O reads.
   // ---------------------------------------------------------------------------
   logic [15:0] sw_val;

`ifdef SW_SYNC_EN
   logic [15:0] sw_meta_q;
   logic [15:0] sw_sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_i;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign sw_val = sw_sync_q;
`else
   assign sw_val = sw_i;
`endif

   // ---------------------------------------------------------------------------
   // Read path: the result word is resolved at the request edge (RAM read,
   // switch sample or zero) and then delayed so that mem_rdata updates
   // READ_LAT-1 edges after the request.
   // ---------------------------------------------------------------------------
   logic [15:0] data_s0;
   logic        last_valid;
   logic [15:0] last_data;

   always_comb begin
      data_s0 = ram_rdata;
      if (req_s0.is_io) begin
         data_s0 = sw_val;
      end else if (req_s0.is_oor) begin
         data_s0 = '0;
      end
   end

   if (READ_LAT == 1) begin : g_no_pipe
      assign last_valid = req_s0.valid;
      assign last_data  = data_s0;
   end else begin : g_pipe
      logic        vld_q [READ_LAT-1];
      logic [15:0] dat_q [READ_LAT-1];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < READ_LAT-1; i++) begin
               vld_q[i] <= 1'b0;
            end
         end else begin
            vld_q[0] <= req_s0.valid;
            for (int i = 1; i < READ_LAT-1; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      // Data stages are qualified by vld_q, so they need no reset.
      always_ff @(posedge clk) begin
         dat_q[0] <= data_s0;
         for (int i = 1; i < READ_LAT-1; i++) begin
            dat_q[i] <= dat_q[i-1];
         end
      end

      assign last_valid = vld_q[READ_LAT-2];
      assign last_data  = dat_q[READ_LAT-2];
   end

   logic [15:0] rdata_q;
   logic [15:0] hex_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (last_valid) begin
         rdata_q <= last_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_q <= '0;
      end else if (hex_we) begin
         hex_q <= mem_wdata;
      end
   end

   assign mem_rdata = rdata_q;
   assign hex_o     = hex_q;

endmodule
